// File: rtl/alu_exec_ctrl.sv
// alu_exec_ctrl: multi-cycle R-type controller (read rs1, read rs2, exec, writeback).
// Option: define ALU_EXEC_CTRL_SAME_SRC_SKIP_EN to skip the rs2 read when rs1==rs2.
module alu_exec_ctrl #(
  parameter logic [6:0] RTYPE_OPCODE = 7'b0110011
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] instruction,
  output logic [4:0]  rf_raddr,
  input  logic [31:0] rf_rdata,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  output logic        alu_enable,
  output logic [2:0]  alu_funct3,
  output logic [6:0]  alu_funct7,
  output logic [31:0] alu_op1,
  output logic [31:0] alu_op2,
  input  logic [31:0] alu_result,
  output logic        done,
  output logic        illegal,
  output logic        busy
);

  typedef enum logic [2:0] {
    IDLE, RD1, RD2, EXEC, WB, ILL
  } state_t;

  state_t      state;
  logic [6:0]  opc, f7;
  logic [2:0]  f3;
  logic [4:0]  rs1, rs2, rd;
  logic        legal;
  logic [4:0]  rs2_q, rd_q;
  logic [2:0]  f3_q;
  logic [6:0]  f7_q;
  logic [31:0] op1_q, op2_q;

  assign opc = instruction[6:0];
  assign rd  = instruction[11:7];
  assign f3  = instruction[14:12];
  assign rs1 = instruction[19:15];
  assign rs2 = instruction[24:20];
  assign f7  = instruction[31:25];

  assign legal = (opc == RTYPE_OPCODE) &&
                 ((f7 == 7'h00) ||
                  ((f7 == 7'h20) &&
                   ((f3 == 3'b000) || (f3 == 3'b101))));

  // Read data and ALU result arrive a cycle after their request,
  // so the issue/writeback cycle forwards them straight through.
`ifdef ALU_EXEC_CTRL_SAME_SRC_SKIP_EN
  logic same_q;
  assign alu_op1 = (state == EXEC && same_q) ? rf_rdata : op1_q;
`else
  assign alu_op1 = op1_q;
`endif
  assign alu_op2  = (state == EXEC) ? rf_rdata : op2_q;
  assign rf_wdata = (state == WB) ? alu_result : '0;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      in_ready   <= 1'b1;
      busy       <= 1'b0;
      rf_raddr   <= '0;
      rf_we      <= 1'b0;
      rf_waddr   <= '0;
      alu_enable <= 1'b0;
      alu_funct3 <= '0;
      alu_funct7 <= '0;
      done       <= 1'b0;
      illegal    <= 1'b0;
      rs2_q      <= '0;
      rd_q       <= '0;
      f3_q       <= '0;
      f7_q       <= '0;
      op1_q      <= '0;
      op2_q      <= '0;
`ifdef ALU_EXEC_CTRL_SAME_SRC_SKIP_EN
      same_q     <= 1'b0;
`endif
    end else begin
      rf_we      <= 1'b0;
      alu_enable <= 1'b0;
      done       <= 1'b0;
      illegal    <= 1'b0;
      unique case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            in_ready <= 1'b0;
            busy     <= 1'b1;
            rs2_q    <= rs2;
            rd_q     <= rd;
            f3_q     <= f3;
            f7_q     <= f7;
`ifdef ALU_EXEC_CTRL_SAME_SRC_SKIP_EN
            same_q   <= (rs1 == rs2);
`endif
            if (legal) begin
              state    <= RD1;
              rf_raddr <= rs1;
            end else begin
              state   <= ILL;
              illegal <= 1'b1;
            end
          end
        end
        RD1: begin
`ifdef ALU_EXEC_CTRL_SAME_SRC_SKIP_EN
          if (same_q) begin
            state      <= EXEC;
            alu_enable <= 1'b1;
            alu_funct3 <= f3_q;
            alu_funct7 <= f7_q;
          end else begin
            state    <= RD2;
            rf_raddr <= rs2_q;
          end
`else
          state    <= RD2;
          rf_raddr <= rs2_q;
`endif
        end
        RD2: begin
          op1_q      <= rf_rdata;
          state      <= EXEC;
          alu_enable <= 1'b1;
          alu_funct3 <= f3_q;
          alu_funct7 <= f7_q;
        end
        EXEC: begin
          op2_q    <= rf_rdata;
`ifdef ALU_EXEC_CTRL_SAME_SRC_SKIP_EN
          if (same_q) op1_q <= rf_rdata;
`endif
          state    <= WB;
          rf_we    <= (rd_q != 5'd0);
          rf_waddr <= rd_q;
          done     <= 1'b1;
        end
        WB, ILL: begin
          state    <= IDLE;
          in_ready <= 1'b1;
          busy     <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_exec_ctrl.sv
// tb_alu_exec_ctrl: cycle-indexed expectation model plus directed literal checks.
// Honours ALU_EXEC_CTRL_SAME_SRC_SKIP_EN when the bench is built with it.
module tb_alu_exec_ctrl;

  localparam int N = 1024;
`ifdef ALU_EXEC_CTRL_SAME_SRC_SKIP_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] instruction = '0;
  logic        in_ready;
  logic [4:0]  rf_raddr;
  logic [31:0] rf_rdata = '0;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        alu_enable;
  logic [2:0]  alu_funct3;
  logic [6:0]  alu_funct7;
  logic [31:0] alu_op1, alu_op2;
  logic [31:0] alu_result = '0;
  logic        done, illegal, busy;

  alu_exec_ctrl dut (
    .clock(clock), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .instruction(instruction),
    .rf_raddr(rf_raddr), .rf_rdata(rf_rdata),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .alu_enable(alu_enable),
    .alu_funct3(alu_funct3), .alu_funct7(alu_funct7),
    .alu_op1(alu_op1), .alu_op2(alu_op2),
    .alu_result(alu_result),
    .done(done), .illegal(illegal), .busy(busy)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)",
               name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] init_val(input int i);
    case (i)
      0: return 32'd0;
      1: return 32'd5;
      2: return 32'd7;
      4: return 32'd9;
      5: return 32'd100;
      6: return 32'd30;
      default: return i * 17 + 3;
    endcase
  endfunction

  function automatic logic [31:0] alu_fn(input logic [31:0] a, b,
                                         input logic [2:0] f3,
                                         input logic [6:0] f7);
    case (f3)
      3'd0: return f7[5] ? a - b : a + b;
      3'd1: return a << b[4:0];
      3'd2: return {31'd0, $signed(a) < $signed(b)};
      3'd3: return {31'd0, a < b};
      3'd4: return a ^ b;
      3'd5: return f7[5] ? $signed(a) >>> b[4:0] : a >> b[4:0];
      3'd6: return a | b;
      default: return a & b;
    endcase
  endfunction

  function automatic logic [31:0] enc(input logic [6:0] f7,
                                      input logic [4:0] rs2, rs1,
                                      input logic [2:0] f3,
                                      input logic [4:0] rd,
                                      input logic [6:0] op);
    return {f7, rs2, rs1, f3, rd, op};
  endfunction

  // Environment: synchronous-read register file and registered ALU.
  logic [31:0] rf [32];
  bit rf_ok = 1'b0;
  always @(posedge clock) begin
    if (!rf_ok) begin
      for (int i = 0; i < 32; i++) rf[i] <= init_val(i);
      rf_ok <= 1'b1;
    end else if (rf_we && rf_waddr != 5'd0) begin
      rf[rf_waddr] <= rf_wdata;
    end
    rf_rdata <= rf[rf_raddr];
    if (alu_enable)
      alu_result <= alu_fn(alu_op1, alu_op2, alu_funct3, alu_funct7);
  end

  // Model: per-cycle expectations scheduled at each handshake.
  bit          e_en [N], e_done [N], e_we [N], e_ill [N], e_rc [N];
  logic [4:0]  e_ra [N], e_wa [N];
  logic [31:0] e_op1 [N], e_op2 [N], e_wd [N];
  logic [2:0]  e_f3 [N];
  logic [6:0]  e_f7 [N];
  logic [31:0] mrf [32];
  bit          m_init = 1'b0;
  int          free_at = 0;
  int          hs_count = 0;
  int          last_hs = 0;

  always @(negedge clock) begin
    int c, lat;
    bit rdy, lg, skp;
    logic [31:0] ins;
    logic [6:0] f7;
    logic [2:0] f3;
    logic [4:0] s1, s2, d;
    c = cyc;
    if (!m_init) begin
      for (int i = 0; i < 32; i++) mrf[i] = init_val(i);
      m_init = 1'b1;
    end
    if (!reset_n) begin
      chk("rst_raddr", rf_raddr, 0);
      chk("rst_waddr", rf_waddr, 0);
      chk("rst_wdata", rf_wdata, 0);
      chk("rst_op1", alu_op1, 0);
      chk("rst_op2", alu_op2, 0);
      chk("rst_f3", alu_funct3, 0);
      chk("rst_f7", alu_funct7, 0);
      chk("rst_we", rf_we, 0);
      chk("rst_en", alu_enable, 0);
      chk("rst_done", done, 0);
      chk("rst_ill", illegal, 0);
      chk("rst_busy", busy, 0);
      for (int k = c; k < c + 8 && k < N; k++) begin
        e_en[k] = 0; e_done[k] = 0; e_we[k] = 0;
        e_ill[k] = 0; e_rc[k] = 0;
      end
      free_at = 0;
    end else begin
      rdy = (c >= free_at);
      chk("in_ready", in_ready, rdy);
      chk("busy", busy, !rdy);
      chk("alu_enable", alu_enable, e_en[c]);
      chk("done", done, e_done[c]);
      chk("illegal", illegal, e_ill[c]);
      chk("rf_we", rf_we, e_we[c]);
      if (e_rc[c]) chk("rf_raddr", rf_raddr, e_ra[c]);
      if (e_en[c]) begin
        chk("alu_op1", alu_op1, e_op1[c]);
        chk("alu_op2", alu_op2, e_op2[c]);
        chk("alu_funct3", alu_funct3, e_f3[c]);
        chk("alu_funct7", alu_funct7, e_f7[c]);
      end
      if (e_done[c] && e_we[c]) begin
        chk("rf_waddr", rf_waddr, e_wa[c]);
        chk("rf_wdata", rf_wdata, e_wd[c]);
        mrf[e_wa[c]] = e_wd[c];
      end
      if (in_valid && rdy) begin
        ins = instruction;
        f7 = ins[31:25]; s2 = ins[24:20]; s1 = ins[19:15];
        f3 = ins[14:12]; d = ins[11:7];
        lg = (ins[6:0] == 7'h33) &&
             (f7 == 0 || (f7 == 7'h20 && (f3 == 0 || f3 == 5)));
        hs_count++;
        last_hs = c;
        if (!lg) begin
          e_ill[c+1] = 1;
          free_at = c + 2;
        end else begin
          skp = SKIP && (s1 == s2);
          lat = skp ? 3 : 4;
          e_rc[c+1] = 1; e_ra[c+1] = s1;
          if (!skp) begin e_rc[c+2] = 1; e_ra[c+2] = s2; end
          e_en[c+lat-1] = 1;
          e_op1[c+lat-1] = mrf[s1];
          e_op2[c+lat-1] = mrf[s2];
          e_f3[c+lat-1] = f3;
          e_f7[c+lat-1] = f7;
          e_done[c+lat] = 1;
          e_we[c+lat] = (d != 0);
          e_wa[c+lat] = d;
          e_wd[c+lat] = alu_fn(mrf[s1], mrf[s2], f3, f7);
          free_at = c + lat + 1;
        end
      end
    end
  end

  task automatic issue(input logic [31:0] ins, input bit hold,
                       output int hs);
    int start, n;
    @(posedge clock); #1;
    in_valid = 1'b1;
    instruction = ins;
    start = hs_count;
    n = 0;
    do begin
      @(posedge clock);
      n++;
    end while (hs_count == start && n < 20);
    #1;
    if (!hold) in_valid = 1'b0;
    if (hs_count == start) begin
      checks++;
      errors++;
      $display("FAIL handshake: none within 20 cycles (cycle %0d)", cyc);
      hs = cyc;
    end else begin
      hs = last_hs;
    end
  endtask

  task automatic goto(input int c);
    int n;
    n = 0;
    @(negedge clock);
    while (cyc < c && n < 50) begin
      @(negedge clock);
      n++;
    end
  endtask

  task automatic settle();
    repeat (8) @(posedge clock);
    #1;
  endtask

  logic [31:0] tbl [8];
  int lat;

  initial begin
    int h, h2;
    tbl[0] = enc(7'h00, 5'd6, 5'd5, 3'd4, 5'd11, 7'h33);
    tbl[1] = enc(7'h20, 5'd6, 5'd5, 3'd5, 5'd12, 7'h33);
    tbl[2] = enc(7'h00, 5'd1, 5'd0, 3'd6, 5'd13, 7'h33);
    tbl[3] = enc(7'h00, 5'd5, 5'd6, 3'd2, 5'd14, 7'h33);
    tbl[4] = enc(7'h01, 5'd2, 5'd1, 3'd0, 5'd15, 7'h33);
    tbl[5] = enc(7'h00, 5'd2, 5'd5, 3'd5, 5'd16, 7'h33);
    tbl[6] = enc(7'h00, 5'd5, 5'd11, 3'd7, 5'd17, 7'h33);
    tbl[7] = enc(7'h00, 5'd2, 5'd1, 3'd0, 5'd18, 7'h3b);
    lat = SKIP ? 3 : 4;

    repeat (3) @(posedge clock);
    #1 reset_n = 1'b1;

    // ADD x3,x1,x2
    issue(32'h002081B3, 1'b0, h);
    goto(h + 1); chk("add_raddr1", rf_raddr, 1);
    goto(h + 2); chk("add_raddr2", rf_raddr, 2);
    goto(h + 3);
    chk("add_en", alu_enable, 1);
    chk("add_op1", alu_op1, 5);
    chk("add_op2", alu_op2, 7);
    goto(h + 4);
    chk("add_we", rf_we, 1);
    chk("add_waddr", rf_waddr, 3);
    chk("add_wdata", rf_wdata, 12);
    chk("add_done", done, 1);
    goto(h + 5); chk("add_ready", in_ready, 1);
    settle();

    // SUB x0,x5,x6
    issue(32'h40628033, 1'b0, h);
    goto(h + 3); chk("sub_f7", alu_funct7, 7'h20);
    goto(h + 4);
    chk("sub_done", done, 1);
    chk("sub_we", rf_we, 0);
    settle();

    // illegal opcode, then funct7=0x20 with funct3=001
    issue(32'h00000013, 1'b0, h);
    goto(h + 1); chk("ill_op", illegal, 1);
    goto(h + 2); chk("ill_ready", in_ready, 1);
    settle();
    issue(enc(7'h20, 5'd2, 5'd1, 3'd1, 5'd3, 7'h33), 1'b0, h);
    goto(h + 1); chk("ill_f7", illegal, 1);
    settle();

    // back-to-back with in_valid held
    issue(enc(7'h00, 5'd2, 5'd1, 3'd0, 5'd7, 7'h33), 1'b1, h);
    issue(enc(7'h20, 5'd1, 5'd7, 3'd0, 5'd8, 7'h33), 1'b0, h2);
    chk("b2b_gap", h2 - h, 5);
    goto(h2 + 4);
    chk("b2b_done", done, 1);
    chk("b2b_wdata", rf_wdata, 7);
    settle();

    // reset during EXEC discards the write
    issue(enc(7'h00, 5'd2, 5'd1, 3'd0, 5'd9, 7'h33), 1'b0, h);
    @(posedge clock);
    @(posedge clock);
    #1 reset_n = 1'b0;
    goto(h + 3); chk("rst_exec_en", alu_enable, 0);
    @(posedge clock);
    #1 reset_n = 1'b1;
    settle();
    chk("rst_no_write", rf[9], 156);
    issue(enc(7'h00, 5'd2, 5'd1, 3'd0, 5'd10, 7'h33), 1'b0, h);
    goto(h + 4);
    chk("post_rst_done", done, 1);
    chk("post_rst_wdata", rf_wdata, 12);
    settle();

    // ADD x4,x4,x4: same-source timing
    issue(32'h00420233, 1'b0, h);
    goto(h + lat - 1);
    chk("same_op1", alu_op1, 9);
    chk("same_op2", alu_op2, 9);
    goto(h + lat);
    chk("same_done", done, 1);
    chk("same_wdata", rf_wdata, 18);
    settle();

    for (int i = 0; i < 8; i++) begin
      issue(tbl[i], 1'b0, h);
      settle();
    end

    repeat (4) @(posedge clock);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
